i2c_slave_wr: RTL and testbench

- I2C target (slave) that answers write transactions from the existing I2C master on the same SCL/SDA pair.
- Accepts START, 7-bit device address + W bit, one register address byte, then data byte(s), then STOP.
- Each accepted data byte is presented as a one-cycle write strobe to a local register file.
- Runs on the system clock and oversamples SCL/SDA; it never drives SCL, and drives SDA low only.

---
 rtl/i2c_slave_wr.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_slave_wr.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_wr.sv
//------------------------------------------------------------------------------
//  Module   : i2c_slave_wr
//  Brief    : I2C write-only target. Oversamples SCL/SDA on clk, accepts
//             START / dev-addr+W / reg-addr / data byte(s) / STOP and presents
//             each accepted data byte as a one-cycle register write strobe.
//             Never drives SCL; pulls SDA low only for ACK.
//  Options  : I2C_SLV_AUTOINC_EN - keep accepting data bytes after the first,
//             incrementing the register address after each strobe.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module i2c_slave_wr #(
  parameter logic [6:0] P_DEV_ADDR    = 7'h50,
  parameter int         P_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_scl,
  inout  wire        io_sda,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_done_flag,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEV_ADDR = 3'd1,
    S_DEV_ACK  = 3'd2,
    S_REG_ADDR = 3'd3,
    S_REG_ACK  = 3'd4,
    S_DATA     = 3'd5,
    S_DATA_ACK = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  localparam logic [3:0] c_LAST_BIT_CNT = 4'd7;

  // Input synchronizers plus one history stage each for edge detection
  logic [P_SYNC_STAGES-1:0] r_scl_sync;
  logic [P_SYNC_STAGES-1:0] r_sda_sync;
  logic                     r_scl_hist;
  logic                     r_sda_hist;

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_last_bit;
  logic [7:0] w_byte;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_sda_drive;
  logic       r_wr_en;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_done;
  logic       r_busy;
  logic       r_wrote;

  state_t     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic [7:0] w_shift_nxt;
  logic       w_drive_nxt;
  logic       w_wr_en_nxt;
  logic [7:0] w_addr_nxt;
  logic [7:0] w_data_nxt;
  logic       w_done_nxt;
  logic       w_busy_nxt;
  logic       w_wrote_nxt;

  // Bring the asynchronous bus pins into the clk domain; idle bus reads high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[P_SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[P_SYNC_STAGES-2:0], io_sda};
      r_scl_hist <= r_scl_sync[P_SYNC_STAGES-1];
      r_sda_hist <= r_sda_sync[P_SYNC_STAGES-1];
    end
  end

  assign w_scl      = r_scl_sync[P_SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[P_SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_hist;
  assign w_scl_fall = ~w_scl & r_scl_hist;
  // START/STOP only count while SCL has been high for both samples
  assign w_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
  assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
  assign w_last_bit = w_scl_rise && (r_cnt == c_LAST_BIT_CNT);
  assign w_byte     = {r_shift[6:0], w_sda};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_shift     <= 8'd0;
      r_sda_drive <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= 8'd0;
      r_wr_data   <= 8'd0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_wrote     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_sda_drive <= w_drive_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_addr_nxt;
      r_wr_data   <= w_data_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_wrote     <= w_wrote_nxt;
    end
  end

  // Next-state and output decode; bus START/STOP override bit handling
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_drive_nxt = r_sda_drive;
    w_wr_en_nxt = 1'b0;
    w_addr_nxt  = r_wr_addr;
    w_data_nxt  = r_wr_data;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_wrote_nxt = r_wrote;

    if (w_start) begin
      // A fresh transaction forgets earlier writes; a repeated start does not
      if (r_state == S_IDLE) begin
        w_wrote_nxt = 1'b0;
      end
      w_state_nxt = S_DEV_ADDR;
      w_cnt_nxt   = 4'd0;
      w_drive_nxt = 1'b0;
      w_busy_nxt  = 1'b1;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
      w_drive_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = r_wrote;
      w_wrote_nxt = 1'b0;
    end else begin
      if (w_scl_rise && (r_state inside {S_DEV_ADDR, S_REG_ADDR, S_DATA})) begin
        w_shift_nxt = w_byte;
        w_cnt_nxt   = r_cnt + 4'd1;
      end

      case (r_state)
        S_DEV_ADDR: begin
          if (w_last_bit) begin
            w_state_nxt = (w_byte == {P_DEV_ADDR, 1'b0}) ? S_DEV_ACK : S_IGNORE;
          end
        end
        S_REG_ADDR: begin
          if (w_last_bit) begin
            w_addr_nxt  = w_byte;
            w_state_nxt = S_REG_ACK;
          end
        end
        S_DATA: begin
          if (w_last_bit) begin
            w_data_nxt  = w_byte;
            w_state_nxt = S_DATA_ACK;
          end
        end
        S_DEV_ACK, S_REG_ACK, S_DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_drive) begin
              // First fall opens the ACK slot; data write strobes with it
              w_drive_nxt = 1'b1;
              if (r_state == S_DATA_ACK) begin
                w_wr_en_nxt = 1'b1;
                w_wrote_nxt = 1'b1;
              end
            end else begin
              // Second fall closes the ACK slot
              w_drive_nxt = 1'b0;
              w_cnt_nxt   = 4'd0;
              case (r_state)
                S_DEV_ACK: w_state_nxt = S_REG_ADDR;
                S_REG_ACK: w_state_nxt = S_DATA;
                default: begin
`ifdef I2C_SLV_AUTOINC_EN
                  w_state_nxt = S_DATA;
                  w_addr_nxt  = r_wr_addr + 8'd1;
`else
                  w_state_nxt = S_IGNORE;
`endif
                end
              endcase
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_sda      = r_sda_drive ? 1'b0 : 1'bz;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_done_flag = r_done;
  assign o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_wr.sv
//------------------------------------------------------------------------------
//  Module   : tb_i2c_slave_wr
//  Brief    : Bench for i2c_slave_wr. A bit-banged I2C master drives the bus;
//             a transaction-level model predicts ACK bits, write strobes and
//             the done pulse from the protocol rules.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_slave_wr;

  localparam int Q = 6;   // quarter bit time in clk cycles
  localparam int H = 12;  // SCL high time in clk cycles
`ifdef I2C_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  wire  sda_bus;

  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       done_flag;
  logic       busy;

  pullup (sda_bus);
  assign sda_bus = sda_m ? 1'bz : 1'b0;

  i2c_slave_wr #(.P_DEV_ADDR(7'h50), .P_SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_scl      (scl_m),
    .io_sda     (sda_bus),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_done_flag(done_flag),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  // Record every strobe and done pulse seen on the outputs
  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (done_flag) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl_m) begin
      sda_m = 1'b1; wclk(Q);
      scl_m = 1'b1; wclk(Q);
    end
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic bus_bit(input logic b);
    sda_m = b;    wclk(Q);
    scl_m = 1'b1; wclk(H);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic bus_ack(output logic acked);
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    acked = (sda_bus === 1'b0);
    wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic bus_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    bus_ack(acked);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(H);
  endtask

  // Transaction-level reference: which bytes get ACKed, which writes happen
  task automatic model(input logic [6:0] dev, input logic rw, input logic [7:0] ra,
                       input int n, input logic [31:0] d, output logic [5:0] acks);
    logic [7:0] a;
    acks = '0;
    exp_q.delete();
    if (dev == 7'h50 && rw == 1'b0) begin
      acks[0] = 1'b1;
      acks[1] = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (AUTOINC || i == 0) begin
          acks[i+2] = 1'b1;
          a = ra + 8'(i);
          exp_q.push_back({a, d[8*i +: 8]});
        end
      end
    end
  endtask

  task automatic run_txn(input logic [6:0] dev, input logic rw, input logic [7:0] ra,
                         input int n, input logic [31:0] d);
    logic [5:0] acks;
    logic ak;
    model(dev, rw, ra, n, d, acks);
    got_q.delete();
    done_cnt = 0;
    bus_start();
    chk("busy_after_start", busy, 1);
    bus_byte({dev, rw}, ak);
    chk("dev_ack", ak, acks[0]);
    bus_byte(ra, ak);
    chk("reg_ack", ak, acks[1]);
    for (int i = 0; i < n; i++) begin
      bus_byte(d[8*i +: 8], ak);
      chk($sformatf("data%0d_ack", i), ak, acks[i+2]);
    end
    bus_stop();
    wclk(4);
    chk("strobe_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("strobe%0d", i), got_q[i], exp_q[i]);
    chk("done_count", done_cnt, (exp_q.size() > 0) ? 1 : 0);
    chk("busy_after_stop", busy, 0);
  endtask

  typedef struct {
    logic [6:0]  dev;
    logic        rw;
    logic [7:0]  ra;
    int          n;
    logic [31:0] d;
    int          exp_n;
    int          exp_done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic ak;
    logic seen;

    tbl[0] = '{7'h50, 1'b0, 8'h12, 1, 32'h0000_00A5, 1, 1};
    tbl[1] = '{7'h51, 1'b0, 8'h12, 1, 32'h0000_00A5, 0, 0};
    tbl[2] = '{7'h50, 1'b1, 8'h12, 1, 32'h0000_0055, 0, 0};
    tbl[3] = '{7'h50, 1'b0, 8'h00, 1, 32'h0000_003C, 1, 1};
    tbl[4] = '{7'h50, 1'b0, 8'hFF, 2, 32'h0000_0201, AUTOINC ? 2 : 1, 1};
    tbl[5] = '{7'h50, 1'b0, 8'h10, 3, 32'h00C3_B2A1, AUTOINC ? 3 : 1, 1};
    tbl[6] = '{7'h50, 1'b0, 8'h80, 0, 32'h0000_0000, 0, 0};

    // Reset state
    wclk(5);
    chk("rst_sda",     sda_bus,   1);
    chk("rst_wr_en",   wr_en,     0);
    chk("rst_wr_addr", wr_addr,   0);
    chk("rst_wr_data", wr_data,   0);
    chk("rst_done",    done_flag, 0);
    chk("rst_busy",    busy,      0);
    rst_n = 1'b1;
    wclk(5);

    // Table-driven transactions
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].dev, tbl[i].rw, tbl[i].ra, tbl[i].n, tbl[i].d);
      chk($sformatf("tbl%0d_strobes", i), got_q.size(), tbl[i].exp_n);
      chk($sformatf("tbl%0d_done", i), done_cnt, tbl[i].exp_done);
    end

    // Read request NACKed, then repeated START recovers into a write
    got_q.delete(); done_cnt = 0;
    bus_start();
    bus_byte(8'hA1, ak); chk("rd_dev_nack", ak, 0);
    bus_byte(8'h00, ak); chk("rd_byte_nack", ak, 0);
    bus_start();
    bus_byte(8'hA0, ak); chk("rec_dev_ack", ak, 1);
    bus_byte(8'h00, ak); chk("rec_reg_ack", ak, 1);
    bus_byte(8'h3C, ak); chk("rec_data_ack", ak, 1);
    bus_stop(); wclk(4);
    chk("rec_strobes", got_q.size(), 1);
    if (got_q.size() > 0) chk("rec_strobe", got_q[0], 16'h003C);
    chk("rec_done", done_cnt, 1);

    // Repeated START after the register byte, then a full write
    got_q.delete(); done_cnt = 0;
    bus_start();
    bus_byte(8'hA0, ak); chk("sr_dev_ack", ak, 1);
    bus_byte(8'h40, ak); chk("sr_reg_ack", ak, 1);
    chk("sr_addr_latched", wr_addr, 8'h40);
    bus_start();
    chk("sr_busy", busy, 1);
    bus_byte(8'hA0, ak); chk("sr2_dev_ack", ak, 1);
    bus_byte(8'h41, ak); chk("sr2_reg_ack", ak, 1);
    bus_byte(8'h77, ak); chk("sr2_data_ack", ak, 1);
    bus_stop(); wclk(4);
    chk("sr_strobes", got_q.size(), 1);
    if (got_q.size() > 0) chk("sr_strobe", got_q[0], 16'h4177);
    chk("sr_done", done_cnt, 1);

    // Reset while the data ACK is being driven
    got_q.delete(); done_cnt = 0;
    bus_start();
    bus_byte(8'hA0, ak); chk("mr_dev_ack", ak, 1);
    bus_byte(8'h10, ak); chk("mr_reg_ack", ak, 1);
    for (int i = 7; i >= 0; i--) bus_bit(logic'((8'h5A >> i) & 8'h01));
    sda_m = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (sda_bus === 1'b0) seen = 1'b1;
      else wclk(1);
    end
    chk("mr_ack_driven", seen, 1);
    chk("mr_strobe_seen", got_q.size(), 1);
    rst_n = 1'b0;
    wclk(1);
    chk("mr_sda_released", sda_bus,   1);
    chk("mr_wr_en",        wr_en,     0);
    chk("mr_wr_addr",      wr_addr,   0);
    chk("mr_wr_data",      wr_data,   0);
    chk("mr_busy",         busy,      0);
    chk("mr_done",         done_flag, 0);
    rst_n = 1'b1;
    wclk(2);
    scl_m = 1'b1;
    wclk(H);
    run_txn(7'h50, 1'b0, 8'h10, 1, 32'h0000_005A);

    // Randomized transactions against the model
    for (int r = 0; r < 12; r++) begin
      logic [6:0] dev;
      logic       rw;
      dev = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      rw  = ($urandom_range(0, 4) == 0);
      run_txn(dev, rw, 8'($urandom), $urandom_range(0, 3), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
